// File: rtl/valu_seq_if.sv
// valu_seq_if -- bundle of the vector-sequencer handshake, register-file,
// lane and write-port signals.
//
//   master : the environment (issuer, vector register file, ALU lane, sink)
//   slave  : the valu_seq sequencer
//
//   start/ready/vl/alu_ctrl/flush  op request handshake and abort
//   elem_idx/elem_a/elem_b         register-file read port
//   lane_a/lane_b/lane_ctrl        operands and op code to the shared lane
//   lane_result                    result back from the lane
//   wr_en/wr_idx/wr_data           result write port
//   done/err/vflags                completion, rejection and result flags
interface valu_seq_if;
  logic        start;
  logic        ready;
  logic [2:0]  vl;
  logic [2:0]  alu_ctrl;
  logic        flush;
  logic [2:0]  elem_idx;
  logic [31:0] elem_a;
  logic [31:0] elem_b;
  logic [31:0] lane_a;
  logic [31:0] lane_b;
  logic [2:0]  lane_ctrl;
  logic [31:0] lane_result;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic        done;
  logic        err;
  logic [1:0]  vflags;

  modport master (
    output start, vl, alu_ctrl, flush, elem_a, elem_b, lane_result,
    input  ready, elem_idx, lane_a, lane_b, lane_ctrl,
           wr_en, wr_idx, wr_data, done, err, vflags
  );

  modport slave (
    input  start, vl, alu_ctrl, flush, elem_a, elem_b, lane_result,
    output ready, elem_idx, lane_a, lane_b, lane_ctrl,
           wr_en, wr_idx, wr_data, done, err, vflags
  );
endinterface

// File: rtl/valu_seq.sv
// valu_seq -- element sequencer for short vector ALU operations.
//
// Accepts a vector op (length 1..5, op code) when idle, walks elem_idx over
// the elements, forwards operands to a shared ALU lane and writes each lane
// result back. A multiply holds each element for MUL_LAT cycles. Completion
// is flagged with a one-cycle done pulse carrying {any_neg, all_zero}.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-low reset
//   bus    valu_seq_if.slave (handshake, operand, lane and write signals)
module valu_seq #(
  parameter int MUL_LAT = 2  // cycles per multiply element, 1..4
) (
  input  logic        clk,
  input  logic        reset,
  valu_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [1:0] BEAT_END = 2'(MUL_LAT - 1);

  state_t      state;
  logic [2:0]  op_q;
  logic [2:0]  vl_q;
  logic [2:0]  elem_idx;
  logic [1:0]  beat;
  logic        any_neg_acc;
  logic        all_zero_acc;
  logic        ready_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  vflags_q;

  logic        legal;
  logic        last_beat;
  logic        last_elem;
  logic        wr_fire;
  logic        next_any_neg;
  logic        next_all_zero;

  assign legal = (bus.vl != 3'd0) && (bus.vl <= 3'd5) &&
                 (bus.alu_ctrl != 3'b101) && (bus.alu_ctrl != 3'b111);

  // Non-mul ops finish an element every cycle; mul waits out MUL_LAT beats.
  assign last_beat = (op_q != OP_MUL) || (beat == BEAT_END);
  assign last_elem = (elem_idx == vl_q - 3'd1);

  // NOTE: the write port is combinational because lane_result is only valid
  // in the cycle its operands are presented. Gating with reset and flush
  // here is what keeps an aborted cycle from leaking a write.
  assign wr_fire = (state == EXEC) && last_beat && !bus.flush && reset;

  assign next_any_neg  = any_neg_acc | bus.lane_result[31];
  assign next_all_zero = all_zero_acc & (bus.lane_result == 32'd0);

  assign bus.wr_en     = wr_fire;
  assign bus.wr_idx    = wr_fire ? elem_idx : 3'd0;
  assign bus.wr_data   = wr_fire ? bus.lane_result : 32'd0;
  assign bus.lane_a    = bus.elem_a;
  assign bus.lane_b    = bus.elem_b;
  assign bus.lane_ctrl = op_q;
  assign bus.elem_idx  = elem_idx;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.vflags    = vflags_q;

  // NOTE: all state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= 3'd0;
      vl_q         <= 3'd0;
      elem_idx     <= 3'd0;
      beat         <= 2'd0;
      any_neg_acc  <= 1'b0;
      all_zero_acc <= 1'b1;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      vflags_q     <= 2'b00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          // flush is deliberately ignored here, even alongside start.
          if (bus.start && ready_q) begin
            vflags_q <= 2'b00;
            if (legal) begin
              state        <= EXEC;
              op_q         <= bus.alu_ctrl;
              vl_q         <= bus.vl;
              elem_idx     <= 3'd0;
              beat         <= 2'd0;
              any_neg_acc  <= 1'b0;
              all_zero_acc <= 1'b1;
              ready_q      <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        EXEC: begin
          if (bus.flush) begin
            state    <= IDLE;
            elem_idx <= 3'd0;
            beat     <= 2'd0;
            ready_q  <= 1'b1;
          end else if (!last_beat) begin
            beat <= beat + 2'd1;
          end else begin
            any_neg_acc  <= next_any_neg;
            all_zero_acc <= next_all_zero;
            beat         <= 2'd0;
            if (last_elem) begin
              state    <= DONE;
              elem_idx <= 3'd0;
              done_q   <= 1'b1;
              vflags_q <= {next_any_neg, next_all_zero};
            end else begin
              elem_idx <= elem_idx + 3'd1;
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq -- self-checking bench for valu_seq.
// Table of directed vectors with hand-derived expectations, a few hand-written
// sequences, then randomized vectors checked against a behavioural model.
module tb_valu_seq;

  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  valu_seq_if bus ();

  valu_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural ALU, used both as the lane and by the reference model.
  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b110:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Vector register file seen through elem_idx.
  logic [31:0] va [8];
  logic [31:0] vb [8];
  assign bus.elem_a      = va[bus.elem_idx];
  assign bus.elem_b      = vb[bus.elem_idx];
  assign bus.lane_result = ref_alu(bus.lane_ctrl, bus.lane_a, bus.lane_b);

  // Event logs.
  typedef struct { int cyc; logic [2:0] idx; logic [31:0] data; } wr_ev_t;
  typedef struct { int cyc; logic [1:0] vf; } done_ev_t;
  wr_ev_t   wq[$];
  done_ev_t dq[$];
  int       eq[$];

  always @(negedge clk) begin
    if (bus.wr_en) wq.push_back('{cyc, bus.wr_idx, bus.wr_data});
    if (bus.done)  dq.push_back('{cyc, bus.vflags});
    if (bus.err)   eq.push_back(cyc);
  end

  typedef struct {
    logic [2:0]        vl;
    logic [2:0]        op;
    logic [4:0][31:0]  a;
    logic [4:0][31:0]  b;
    bit                flush_acc;
    int                abort_rel;   // 0: none, else cycle offset from accept
    bit                abort_rst;   // abort by reset instead of flush
    bit                exp_err;
    int                exp_nwr;
    logic [4:0][31:0]  exp_data;
    int                exp_done_rel; // 0: no done expected
    logic [1:0]        exp_vf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0][31:0] pk5(input int x0, input int x1,
                                           input int x2, input int x3,
                                           input int x4);
    logic [4:0][31:0] r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  function automatic vec_t mk(input int vl, input int op,
                              input logic [4:0][31:0] a,
                              input logic [4:0][31:0] b);
    vec_t v;
    v.vl = 3'(vl); v.op = 3'(op); v.a = a; v.b = b;
    v.flush_acc = 0; v.abort_rel = 0; v.abort_rst = 0;
    v.exp_err = 0; v.exp_nwr = 0; v.exp_data = '0;
    v.exp_done_rel = 0; v.exp_vf = 2'b00;
    return v;
  endfunction

  // Reference model: derives expectations from the op rules directly.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   lat = (v.op == 3'b110) ? MUL_LAT : 1;
    bit   any_neg = 0;
    bit   all_zero = 1;
    bit   aborted;
    logic [31:0] d;
    r.exp_nwr = 0; r.exp_data = '0; r.exp_done_rel = 0; r.exp_vf = 2'b00;
    if (v.vl == 0 || v.vl > 5 || v.op == 3'b101 || v.op == 3'b111) begin
      r.exp_err = 1;
      return r;
    end
    r.exp_err = 0;
    aborted = (v.abort_rel != 0) && (v.abort_rel <= int'(v.vl) * lat);
    for (int i = 0; i < int'(v.vl); i++) begin
      if (aborted && (i + 1) * lat >= v.abort_rel) break;
      d = ref_alu(v.op, v.a[i], v.b[i]);
      r.exp_data[r.exp_nwr] = d;
      r.exp_nwr++;
      any_neg  = any_neg | d[31];
      all_zero = all_zero & (d == 32'd0);
    end
    if (!aborted) begin
      r.exp_done_rel = int'(v.vl) * lat + 1;
      r.exp_vf = {any_neg, all_zero};
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int t0;
    int lat = (v.op == 3'b110) ? MUL_LAT : 1;
    int span = int'(v.vl) * lat + 2;
    int nw;
    @(posedge clk); #1;
    wq.delete(); dq.delete(); eq.delete();
    for (int i = 0; i < 5; i++) begin
      va[i] = v.a[i];
      vb[i] = v.b[i];
    end
    bus.vl = v.vl; bus.alu_ctrl = v.op;
    bus.start = 1'b1; bus.flush = v.flush_acc;
    t0 = cyc;
    for (int k = 1; k <= span; k++) begin
      @(posedge clk); #1;
      // A legal op also keeps start high one extra cycle; it must be ignored.
      bus.start = (k == 1) && !v.exp_err;
      bus.flush = (v.abort_rel == k) && !v.abort_rst;
      reset     = !((v.abort_rel == k) && v.abort_rst);
    end
    @(negedge clk);
    check({nm, ".err_cnt"}, eq.size(), 32'(v.exp_err));
    if (v.exp_err && eq.size() > 0) check({nm, ".err_cyc"}, eq[0] - t0, 1);
    check({nm, ".wr_cnt"}, wq.size(), v.exp_nwr);
    nw = (wq.size() < v.exp_nwr) ? wq.size() : v.exp_nwr;
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s.wr%0d_idx", nm, i), 32'(wq[i].idx), i);
      check($sformatf("%s.wr%0d_data", nm, i), wq[i].data, v.exp_data[i]);
      check($sformatf("%s.wr%0d_cyc", nm, i), wq[i].cyc - t0, (i + 1) * lat);
    end
    check({nm, ".done_cnt"}, dq.size(), (v.exp_done_rel != 0) ? 1 : 0);
    if (v.exp_done_rel != 0 && dq.size() > 0) begin
      check({nm, ".done_cyc"}, dq[0].cyc - t0, v.exp_done_rel);
      check({nm, ".vflags"}, 32'(dq[0].vf), 32'(v.exp_vf));
    end
    check({nm, ".ready_end"}, 32'(bus.ready), 1);
    check({nm, ".idx_end"}, 32'(bus.elem_idx), 0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   lat;

    for (int i = 0; i < 8; i++) begin
      va[i] = 32'hdead_0000 + 32'(i);
      vb[i] = 32'hbeef_0000 + 32'(i);
    end
    bus.start = 1'b0; bus.flush = 1'b0; bus.vl = 3'd0; bus.alu_ctrl = 3'd0;

    // Reset state, checked while reset is still low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready",     32'(bus.ready), 1);
    check("rst.done",      32'(bus.done), 0);
    check("rst.err",       32'(bus.err), 0);
    check("rst.wr_en",     32'(bus.wr_en), 0);
    check("rst.elem_idx",  32'(bus.elem_idx), 0);
    check("rst.wr_idx",    32'(bus.wr_idx), 0);
    check("rst.wr_data",   bus.wr_data, 0);
    check("rst.vflags",    32'(bus.vflags), 0);
    check("rst.lane_ctrl", 32'(bus.lane_ctrl), 0);
    reset = 1'b1;

    // Directed vectors with hand-derived expectations.
    v = mk(3, 0, pk5(1, 2, 3, 0, 0), pk5(10, 20, 30, 0, 0));
    v.exp_nwr = 3; v.exp_data = pk5(11, 22, 33, 0, 0);
    v.exp_done_rel = 4; v.exp_vf = 2'b00; tbl.push_back(v);

    v = mk(5, 1, pk5(7, 7, 7, 7, 7), pk5(7, 7, 7, 7, 7));
    v.exp_nwr = 5; v.exp_data = pk5(0, 0, 0, 0, 0);
    v.exp_done_rel = 6; v.exp_vf = 2'b01; tbl.push_back(v);

    v = mk(2, 6, pk5(3, -2, 0, 0, 0), pk5(4, 5, 0, 0, 0));
    v.exp_nwr = 2; v.exp_data = pk5(12, -10, 0, 0, 0);
    v.exp_done_rel = 5; v.exp_vf = 2'b10; tbl.push_back(v);

    v = mk(0, 0, pk5(1, 1, 1, 1, 1), pk5(1, 1, 1, 1, 1));
    v.exp_err = 1; tbl.push_back(v);
    v = mk(6, 0, pk5(1, 1, 1, 1, 1), pk5(1, 1, 1, 1, 1));
    v.exp_err = 1; tbl.push_back(v);
    v = mk(3, 5, pk5(1, 1, 1, 1, 1), pk5(1, 1, 1, 1, 1));
    v.exp_err = 1; tbl.push_back(v);
    v = mk(2, 7, pk5(1, 1, 1, 1, 1), pk5(1, 1, 1, 1, 1));
    v.exp_err = 1; tbl.push_back(v);

    // Flush mid-op: only the first element is written.
    v = mk(4, 4, pk5(5, 6, 7, 8, 0), pk5(3, 3, 3, 3, 0));
    v.abort_rel = 2; v.exp_nwr = 1; v.exp_data = pk5(6, 0, 0, 0, 0);
    tbl.push_back(v);

    // Reset mid-op, then a fresh op completes normally.
    v = mk(5, 0, pk5(1, 2, 3, 4, 5), pk5(0, 0, 0, 0, 0));
    v.abort_rel = 3; v.abort_rst = 1; v.exp_nwr = 2;
    v.exp_data = pk5(1, 2, 0, 0, 0); tbl.push_back(v);
    v = mk(1, 2, pk5('hf0, 0, 0, 0, 0), pk5('h3c, 0, 0, 0, 0));
    v.exp_nwr = 1; v.exp_data = pk5('h30, 0, 0, 0, 0);
    v.exp_done_rel = 2; v.exp_vf = 2'b00; tbl.push_back(v);

    // Flush in the same cycle as start is ignored.
    v = mk(2, 3, pk5(0, 0, 0, 0, 0), pk5(0, 0, 0, 0, 0));
    v.flush_acc = 1; v.exp_nwr = 2; v.exp_data = pk5(0, 0, 0, 0, 0);
    v.exp_done_rel = 3; v.exp_vf = 2'b01; tbl.push_back(v);

    // Flush during DONE has no effect.
    v = mk(1, 0, pk5(4, 0, 0, 0, 0), pk5(5, 0, 0, 0, 0));
    v.abort_rel = 2; v.exp_nwr = 1; v.exp_data = pk5(9, 0, 0, 0, 0);
    v.exp_done_rel = 2; v.exp_vf = 2'b00; tbl.push_back(v);

    // Multiply over three elements with negatives.
    v = mk(3, 6, pk5(-1, 0, 2, 0, 0), pk5(1, 9, -3, 0, 0));
    v.exp_nwr = 3; v.exp_data = pk5(-1, 0, -6, 0, 0);
    v.exp_done_rel = 7; v.exp_vf = 2'b10; tbl.push_back(v);

    // Reset on the last beat of the second multiply element.
    v = mk(3, 6, pk5(2, 3, 4, 0, 0), pk5(2, 3, 4, 0, 0));
    v.abort_rel = 4; v.abort_rst = 1; v.exp_nwr = 1;
    v.exp_data = pk5(4, 0, 0, 0, 0); tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("t%0d", i));

    // Flush while idle: nothing happens.
    @(posedge clk); #1;
    wq.delete(); dq.delete(); eq.delete();
    bus.flush = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush.ready", 32'(bus.ready), 1);
    check("idle_flush.events", 32'(wq.size() + dq.size() + eq.size()), 0);

    // Reset wins over a same-cycle legal start.
    @(posedge clk); #1;
    bus.vl = 3'd2; bus.alu_ctrl = 3'd0; bus.start = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start.ready", 32'(bus.ready), 1);
    check("rst_start.events", 32'(wq.size() + dq.size() + eq.size()), 0);

    // Randomized vectors against the reference model.
    for (int n = 0; n < 40; n++) begin
      v = mk($urandom_range(0, 6), $urandom_range(0, 7), '0, '0);
      if ($urandom_range(0, 3) == 0) v.op = 3'b110;
      for (int i = 0; i < 5; i++) begin
        v.a[i] = $urandom();
        v.b[i] = ($urandom_range(0, 3) == 0) ? v.a[i] : $urandom();
        if ($urandom_range(0, 4) == 0) v.a[i][31] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) begin
        v.a = '0;
        v.b = '0;
      end
      v.flush_acc = ($urandom_range(0, 7) == 0);
      lat = (v.op == 3'b110) ? MUL_LAT : 1;
      if (v.vl >= 1 && v.vl <= 5 && $urandom_range(0, 3) == 0) begin
        v.abort_rel = $urandom_range(1, int'(v.vl) * lat);
        v.abort_rst = $urandom_range(0, 1) == 1;
      end
      v = model(v);
      run_vec(v, $sformatf("r%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/valu_seq.md
VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 Parameter MUL_LAT, default 2, SHALL set the cycles per element for a multiply (legal 1..4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on clk rising edge.
REQ-004 start  input  1  vector-op request, qualified by ready.
REQ-005 ready  output  1  high only in IDLE; start accepted when start&ready.
REQ-006 vl  input  3  vector length; legal 1..5, captured on accept.
REQ-007 alu_ctrl  input  3  op code; 000 add, 001 sub, 010 and, 011 or, 100 xor, 110 mul; captured on accept.
REQ-008 flush  input  1  abort of an in-flight op.
REQ-009 elem_idx  output  3  element index presented to the vector register file.
REQ-010 elem_a, elem_b  input  32 each  operands for elem_idx, valid in the same cycle.
REQ-011 lane_a, lane_b  output  32 each  operands driven to the shared ALU lane.
REQ-012 lane_ctrl  output  3  captured op code driven to the lane.
REQ-013 lane_result  input  32  lane result; combinational for non-mul; valid on the final cycle of a mul element.
REQ-014 wr_en, wr_idx, wr_data  output  1/3/32  result write port.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  one-cycle pulse on a rejected request.
REQ-017 vflags  output  2  {any_neg, all_zero} of the completed op; valid while done=1.

Function
REQ-018 States SHALL be IDLE, EXEC, DONE; transitions SHALL be IDLE->EXEC on a legal accept, EXEC->DONE after the last element, and DONE->IDLE unconditionally.
REQ-019 An accept with vl=0, vl>5, or alu_ctrl in {101,111} SHALL pulse err the next cycle, stay in IDLE, and produce no writes or done.
REQ-020 On a legal accept at edge T the block SHALL enter EXEC with elem_idx=0, at T+1.
REQ-021 In EXEC, lane_a/lane_b SHALL equal elem_a/elem_b, and lane_ctrl SHALL equal the captured op.
REQ-022 For a non-mul op, each EXEC cycle SHALL assert wr_en with wr_idx=elem_idx and wr_data=lane_result, then increment elem_idx.
REQ-023 For a mul op, each element SHALL hold elem_idx for MUL_LAT cycles; wr_en SHALL assert only on the last of those cycles.
REQ-024 Writes SHALL occur for indices 0..vl-1 in ascending order, exactly once each.
REQ-025 Non-mul latency: writes SHALL occur at T+1..T+vl, done at T+vl+1, and ready at T+vl+2.
REQ-026 Mul latency: done SHALL occur at T+vl*MUL_LAT+1.
REQ-027 vflags SHALL accumulate over written results: any_neg = OR of wr_data[31]; all_zero = AND of (wr_data==0).
REQ-028 vflags SHALL clear on each accept.
REQ-029 While in EXEC, start SHALL be ignored (ready=0); no queueing.
REQ-030 flush in EXEC SHALL suppress wr_en in that cycle, return to IDLE next cycle, and produce no done.
REQ-031 flush in IDLE or DONE SHALL have no effect.
REQ-032 flush and start in the same IDLE cycle: flush SHALL be ignored and start accepted.
REQ-033 elem_idx SHALL never exceed vl-1 and SHALL return to 0 in IDLE.

Reset
REQ-034 With reset=0 at a rising edge, the block SHALL enter IDLE.
REQ-035 Reset SHALL set ready=1 and clear done, err, wr_en, elem_idx, wr_idx, wr_data, vflags, and lane_ctrl to 0.
REQ-036 Reset asserted mid-EXEC SHALL abort with no further writes and no done pulse.
REQ-037 Reset SHALL take priority over start and flush.

Verification
REQ-038 vl=3, add, A={1,2,3}, B={10,20,30} -> writes (0,11),(1,22),(2,33) at T+1..T+3; done at T+4 with vflags=00.
REQ-039 vl=5, sub, A=B={7,7,7,7,7} -> five writes of 0; done at T+6 with vflags=01.
REQ-040 vl=2, mul, MUL_LAT=2, A={3,-2}, B={4,5} -> writes 12 at T+2 and -10 at T+4; done at T+5 with vflags=10.
REQ-041 vl=0, then vl=6, then alu_ctrl=101 -> err pulse each time, no wr_en, ready stays 1.
REQ-042 vl=4 xor, flush at T+2 -> single write at T+1, no write at T+2, IDLE at T+3, no done.
REQ-043 vl=5 add, reset=0 at T+3 -> exactly two writes, ready=1 next cycle, then a fresh start completes normally.
